pc_gen: RTL and testbench

//  Program-counter generator and fetch sequencer; sits directly upstream of pc_delay and the instruction BRAM.

---
 rtl/pc_gen_pkg.sv | 27 ++
 rtl/pc_gen_next.sv | 35 +++
 rtl/pc_gen.sv | 112 +++++++++++
 tb/tb_pc_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: PC width, FSM state encoding,
// flush counter width and the next-PC source select.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package pc_gen_pkg;

  localparam int PC_W = `PC_WIDTH;

  localparam int PCG_FLUSH_CNT_W = 2;

  typedef enum logic [1:0] {
    PCG_ST_IDLE  = 2'd0,
    PCG_ST_RUN   = 2'd1,
    PCG_ST_FLUSH = 2'd2
  } pcg_state_t;

  typedef enum logic [2:0] {
    NXT_HOLD   = 3'd0,
    NXT_INC    = 3'd1,
    NXT_TARGET = 3'd2,
    NXT_TRAP   = 3'd3,
    NXT_RESET  = 3'd4
  } pc_sel_t;

endpackage

// File: rtl/pc_gen_next.sv
// Combinational next-PC mux: hold, sequential increment, aligned jump target,
// trap vector or reset PC.
module pc_gen_next
  import pc_gen_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              PC_STEP     = 4,
  parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'('h100)
) (
  input  logic [2:0]      sel,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_next
);

  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(PC_STEP - 1));

  // Redirect addresses drop the sub-step bits so fetches stay step-aligned.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  always_comb begin
    pc_next = pc;
    case (pc_sel_t'(sel))
      NXT_INC:    pc_next = pc + STEP;
      NXT_TARGET: pc_next = align_pc(target);
      NXT_TRAP:   pc_next = align_pc(TRAP_VECTOR);
      NXT_RESET:  pc_next = RESET_PC;
      default:    pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator and fetch sequencer (IDLE/RUN/FLUSH).
// Optional trap redirect with EPC capture is compiled in by defining PC_TRAP_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              PC_STEP      = 4,
  parameter int              FLUSH_CYCLES = 1,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = PC_W'('h100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            work_ena,
  input  logic            stall,
  input  logic            pc_jump,
  input  logic [PC_W-1:0] pc_target,
`ifdef PC_TRAP_EN
  input  logic            trap_i,
  output logic [PC_W-1:0] epc_o,
`endif
  output logic [PC_W-1:0] pc_o,
  output logic            inst_valid_o,
  output logic            flush_o
);

  localparam logic [PCG_FLUSH_CNT_W-1:0] FLUSH_LOAD = PCG_FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam pcg_state_t AFTER_REDIRECT = (FLUSH_CYCLES == 1) ? PCG_ST_RUN : PCG_ST_FLUSH;

  pcg_state_t                 state_q, state_d;
  logic [PCG_FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  pc_sel_t                    sel;
  logic [PC_W-1:0]            pc_next;
  logic                       valid_d, flush_d;
  logic                       trap_req, epc_load;

`ifdef PC_TRAP_EN
  assign trap_req = trap_i;
`else
  assign trap_req = 1'b0;
`endif

  pc_gen_next #(
    .RESET_PC    (RESET_PC),
    .PC_STEP     (PC_STEP),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next (
    .sel     (sel),
    .pc      (pc_o),
    .target  (pc_target),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel      = NXT_HOLD;
    valid_d  = inst_valid_o;
    flush_d  = 1'b0;
    epc_load = 1'b0;
    if (!work_ena) begin
      state_d = PCG_ST_IDLE;
      sel     = NXT_RESET;
      valid_d = 1'b0;
    end else if (state_q == PCG_ST_IDLE) begin
      // First RUN cycle presents RESET_PC; its fetch is flagged valid one cycle later.
      state_d = PCG_ST_RUN;
      sel     = NXT_RESET;
      valid_d = 1'b0;
    end else if (trap_req || pc_jump) begin
      sel      = trap_req ? NXT_TRAP : NXT_TARGET;
      epc_load = trap_req;
      flush_d  = 1'b1;
      valid_d  = 1'b0;
      cnt_d    = FLUSH_LOAD;
      state_d  = AFTER_REDIRECT;
    end else if (stall) begin
      valid_d = (state_q == PCG_ST_RUN) ? inst_valid_o : 1'b0;
    end else if (state_q == PCG_ST_RUN) begin
      sel     = NXT_INC;
      valid_d = 1'b1;
    end else begin
      sel     = NXT_INC;
      valid_d = 1'b0;
      if (cnt_q == '0) state_d = PCG_ST_RUN;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PCG_ST_IDLE;
      cnt_q        <= '0;
      pc_o         <= RESET_PC;
      inst_valid_o <= 1'b0;
      flush_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_o         <= pc_next;
      inst_valid_o <= valid_d;
      flush_o      <= flush_d;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)           epc_o <= '0;
    else if (epc_load) epc_o <= pc_o;
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with a single-cycle flush, one with
// a three-cycle flush; trap checks run when PC_TRAP_EN is defined.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            work_ena, stall, pc_jump;
  logic [PC_W-1:0] pc_target;
  logic [PC_W-1:0] pc;
  logic            valid, flush;
  logic            work3, stall3, jump3;
  logic [PC_W-1:0] target3;
  logic [PC_W-1:0] pc3;
  logic            valid3, flush3;
`ifdef PC_TRAP_EN
  logic            trap, trap3;
  logic [PC_W-1:0] epc, epc3;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_gen #(.FLUSH_CYCLES(1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .work_ena     (work_ena),
    .stall        (stall),
    .pc_jump      (pc_jump),
    .pc_target    (pc_target),
`ifdef PC_TRAP_EN
    .trap_i       (trap),
    .epc_o        (epc),
`endif
    .pc_o         (pc),
    .inst_valid_o (valid),
    .flush_o      (flush)
  );

  pc_gen #(.FLUSH_CYCLES(3)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .work_ena     (work3),
    .stall        (stall3),
    .pc_jump      (jump3),
    .pc_target    (target3),
`ifdef PC_TRAP_EN
    .trap_i       (trap3),
    .epc_o        (epc3),
`endif
    .pc_o         (pc3),
    .inst_valid_o (valid3),
    .flush_o      (flush3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] p, input logic v, input logic f);
    chk({tag, ".pc"}, 32'(pc), p);
    chk({tag, ".vld"}, 32'(valid), 32'(v));
    chk({tag, ".flush"}, 32'(flush), 32'(f));
  endtask

  task automatic chk3(input string tag, input logic [31:0] p, input logic v, input logic f);
    chk({tag, ".pc"}, 32'(pc3), p);
    chk({tag, ".vld"}, 32'(valid3), 32'(v));
    chk({tag, ".flush"}, 32'(flush3), 32'(f));
  endtask

  initial begin
    rst = 1'b1; work_ena = 1'b0; stall = 1'b0; pc_jump = 1'b0; pc_target = '0;
    work3 = 1'b0; stall3 = 1'b0; jump3 = 1'b0; target3 = '0;
`ifdef PC_TRAP_EN
    trap = 1'b0; trap3 = 1'b0;
`endif
    step(); step();
    chk1("reset", 32'h0, 1'b0, 1'b0);
    chk3("reset3", 32'h0, 1'b0, 1'b0);
`ifdef PC_TRAP_EN
    chk("reset.epc", 32'(epc), 32'h0);
`endif

    // Start-up sequence 0,4,8,12 with valid 0,1,1,1
    rst = 1'b0; work_ena = 1'b1;
    step(); chk1("start0", 32'h0, 1'b0, 1'b0);
    step(); chk1("start1", 32'h4, 1'b1, 1'b0);
    step(); chk1("start2", 32'h8, 1'b1, 1'b0);
    step(); chk1("start3", 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk1("at20", 32'h20, 1'b1, 1'b0);

    // Stall holds for three cycles, then resumes
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk1("stall", 32'h20, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step(); chk1("unstall", 32'h24, 1'b1, 1'b0);

    // Redirect to 0x10, then from 0x10 to 0x83 (aligned to 0x80)
    pc_jump = 1'b1; pc_target = 32'h10;
    step(); chk1("jmp10", 32'h10, 1'b0, 1'b1);
    pc_target = 32'h83;
    step(); chk1("jmp83", 32'h80, 1'b0, 1'b1);
    pc_jump = 1'b0;
    step(); chk1("post83", 32'h84, 1'b1, 1'b0);

    // Jump taken despite stall; stall then holds the target
    stall = 1'b1; pc_jump = 1'b1; pc_target = 32'h200;
    step(); chk1("jmpstall", 32'h200, 1'b0, 1'b1);
    pc_jump = 1'b0;
    step(); chk1("stallhold", 32'h200, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk1("resume", 32'h204, 1'b1, 1'b0);

    // Wrap at the top of the address space
    pc_jump = 1'b1; pc_target = 32'hFFFF_FFFF;
    step(); chk1("jmpmax", 32'hFFFF_FFFC, 1'b0, 1'b1);
    pc_jump = 1'b0;
    step(); chk1("wrap", 32'h0, 1'b1, 1'b0);
    step(); chk1("wrap+1", 32'h4, 1'b1, 1'b0);

    // work_ena low parks at RESET_PC, outranking a jump
    work_ena = 1'b0; pc_jump = 1'b1; pc_target = 32'h300;
    step(); chk1("park", 32'h0, 1'b0, 1'b0);
    pc_jump = 1'b0;
    step(); chk1("park2", 32'h0, 1'b0, 1'b0);
    work_ena = 1'b1;
    step(); chk1("rerun0", 32'h0, 1'b0, 1'b0);
    step(); chk1("rerun1", 32'h4, 1'b1, 1'b0);

`ifdef PC_TRAP_EN
    pc_jump = 1'b1; pc_target = 32'h3C;
    step(); chk1("jmp3c", 32'h3C, 1'b0, 1'b1);
    trap = 1'b1; pc_target = 32'h80;
    step(); chk1("trap", 32'h100, 1'b0, 1'b1);
    chk("trap.epc", 32'(epc), 32'h3C);
    trap = 1'b0; pc_jump = 1'b0;
    step(); chk1("posttrap", 32'h104, 1'b1, 1'b0);
`endif

    // Three-cycle flush instance
    work3 = 1'b1;
    step(); chk3("f3.start0", 32'h0, 1'b0, 1'b0);
    step(); chk3("f3.start1", 32'h4, 1'b1, 1'b0);
    step(); chk3("f3.start2", 32'h8, 1'b1, 1'b0);
    jump3 = 1'b1; target3 = 32'h83;
    step(); chk3("f3.jmp", 32'h80, 1'b0, 1'b1);
    jump3 = 1'b0;
    step(); chk3("f3.fl1", 32'h84, 1'b0, 1'b0);
    stall3 = 1'b1;
    step(); chk3("f3.flstall", 32'h84, 1'b0, 1'b0);
    stall3 = 1'b0; jump3 = 1'b1; target3 = 32'h40;
    step(); chk3("f3.rejmp", 32'h40, 1'b0, 1'b1);
    jump3 = 1'b0;
    step(); chk3("f3.rfl1", 32'h44, 1'b0, 1'b0);
    step(); chk3("f3.rfl2", 32'h48, 1'b0, 1'b0);
    step(); chk3("f3.rfl3", 32'h4C, 1'b0, 1'b0);
    step(); chk3("f3.run", 32'h50, 1'b1, 1'b0);

    // work_ena dropped mid-flush returns to IDLE
    jump3 = 1'b1; target3 = 32'h100;
    step(); chk3("f3.jmp100", 32'h100, 1'b0, 1'b1);
    jump3 = 1'b0; work3 = 1'b0;
    step(); chk3("f3.park", 32'h0, 1'b0, 1'b0);
    work3 = 1'b1;
    step(); chk3("f3.idle2run", 32'h0, 1'b0, 1'b0);
    step(); chk3("f3.run4", 32'h4, 1'b1, 1'b0);

    // Reset mid-flush
    jump3 = 1'b1; target3 = 32'h200;
    step(); chk3("f3.jmp200", 32'h200, 1'b0, 1'b1);
    jump3 = 1'b0; rst = 1'b1;
    step(); chk3("f3.rst", 32'h0, 1'b0, 1'b0);
    chk1("rst", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk3("f3.after0", 32'h0, 1'b0, 1'b0);
    step(); chk3("f3.after1", 32'h4, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
